// File: rtl/writeback_unit.sv
// Retirement stage: selects and extends the writeback value, drives the register-file
// write port, stalls loads until memory responds (with a timeout), and counts retirements.
module writeback_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_wen,
  input  logic [1:0]       in_wb_sel,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_pc,
  input  logic [2:0]       in_load_funct3,
  input  logic [1:0]       in_load_addr_lo,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic [4:0]       Rw,
  output logic             RegWr,
  output logic [31:0]      busW,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             err_timeout
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [4:0]    p_rd;
  logic          p_wen;
  logic [2:0]    p_funct3;
  logic [1:0]    p_addr_lo;
  logic          in_is_load_c;
  logic [31:0]   fast_result_c;

  // Extract the addressed byte/half and extend it according to the load type.
  function automatic logic [31:0] load_ext(input logic [2:0]  funct3,
                                           input logic [1:0]  addr_lo,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Result for an instruction that completes in the cycle it is accepted.
  always_comb begin
    in_is_load_c  = (in_wb_sel == SEL_LOAD);
    fast_result_c = in_alu_result;
    if (in_is_load_c)
      fast_result_c = load_ext(in_load_funct3, in_load_addr_lo, mem_rdata);
    else if (in_wb_sel == SEL_PC4)
      fast_result_c = in_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      tcnt        <= '0;
      p_rd        <= '0;
      p_wen       <= 1'b0;
      p_funct3    <= '0;
      p_addr_lo   <= '0;
      Rw          <= '0;
      RegWr       <= 1'b0;
      busW        <= '0;
      retire_cnt  <= '0;
      err_timeout <= 1'b0;
    end else begin
      RegWr <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_is_load_c || mem_rvalid) begin
              Rw         <= in_rd;
              busW       <= fast_result_c;
              RegWr      <= in_reg_wen && (in_rd != 5'd0);
              retire_cnt <= retire_cnt + CNT_W'(1);
            end else begin
              p_rd      <= in_rd;
              p_wen     <= in_reg_wen;
              p_funct3  <= in_load_funct3;
              p_addr_lo <= in_load_addr_lo;
              tcnt      <= '0;
              state     <= WAIT_MEM;
              in_ready  <= 1'b0;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            Rw         <= p_rd;
            busW       <= load_ext(p_funct3, p_addr_lo, mem_rdata);
            RegWr      <= p_wen && (p_rd != 5'd0);
            retire_cnt <= retire_cnt + CNT_W'(1);
            state      <= IDLE;
            in_ready   <= 1'b1;
          end else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
            // Abandon the load: counted as retired, but nothing is written.
            err_timeout <= 1'b1;
            retire_cnt  <= retire_cnt + CNT_W'(1);
            state       <= IDLE;
            in_ready    <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit, checked against a transaction-level model
// of writes, retire count and the sticky timeout flag.
module tb_writeback_unit;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_wen;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic [2:0]  in_load_funct3;
  logic [1:0]  in_load_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  Rw;
  logic        RegWr;
  logic [31:0] busW;
  logic [CNT_W-1:0] retire_cnt;
  logic        err_timeout;

  writeback_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_wen(in_reg_wen), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc(in_pc),
    .in_load_funct3(in_load_funct3), .in_load_addr_lo(in_load_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .Rw(Rw), .RegWr(RegWr), .busW(busW),
    .retire_cnt(retire_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  logic [4:0]  exp_rw;
  logic [31:0] exp_busw;
  logic [31:0] exp_cnt;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load extension computed arithmetically from the load semantics.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    longint v;
    longint word;
    word = longint'(w);
    case (f3)
      3'b000, 3'b100: begin
        v = (word >> (8 * int'(lo))) % 256;
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (word >> (16 * (int'(lo) / 2))) % 65536;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = word;
    endcase
    return 32'(v);
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_rw"},   32'(Rw), 32'(exp_rw));
    check({tag, "_busw"}, busW, exp_busw);
    check({tag, "_cnt"},  retire_cnt, exp_cnt);
    check({tag, "_err"},  32'(err_timeout), 32'(exp_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    rst = 1'b0;
    exp_rw = '0; exp_busw = '0; exp_cnt = '0; exp_err = 1'b0;
    check("rst_wr", 32'(RegWr), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check_state("rst");
  endtask

  task automatic completed(input logic [4:0] rd, input logic wen, input logic [31:0] val);
    exp_cnt  = exp_cnt + 32'd1;
    exp_rw   = rd;
    exp_busw = val;
    check("done_wr", 32'(RegWr), 32'(wen && rd != 5'd0));
    check("done_ready", 32'(in_ready), 32'd1);
    check_state("done");
  endtask

  task automatic idle_cycle();
    in_valid   = 1'b0;
    mem_rvalid = 1'($urandom % 2);
    mem_rdata  = $urandom;
    tick();
    check("idle_wr", 32'(RegWr), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check_state("idle");
  endtask

  // wait_cycles: WAIT_MEM cycles without a response before data arrives (loads only).
  task automatic do_op(input logic [1:0] sel, input logic [4:0] rd, input logic wen,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [2:0] f3, input logic [1:0] lo,
                       input logic [31:0] rdata, input int wait_cycles);
    in_valid = 1'b1;
    in_wb_sel = sel; in_rd = rd; in_reg_wen = wen;
    in_alu_result = alu; in_pc = pc; in_load_funct3 = f3; in_load_addr_lo = lo;
    if (sel != 2'b01) begin
      mem_rvalid = 1'($urandom % 2);
      mem_rdata  = $urandom;
      tick();
      completed(rd, wen, (sel == 2'b10) ? pc + 32'd4 : alu);
    end else if (wait_cycles == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick();
      completed(rd, wen, ref_load(f3, lo, rdata));
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      tick();
      for (int k = 0; k < wait_cycles && k < int'(MEM_TIMEOUT); k++) begin
        check("wait_ready", 32'(in_ready), 32'd0);
        check("wait_wr", 32'(RegWr), 32'd0);
        in_valid  = 1'($urandom % 2);
        in_wb_sel = 2'($urandom);
        tick();
      end
      if (wait_cycles >= int'(MEM_TIMEOUT)) begin
        exp_cnt = exp_cnt + 32'd1;
        exp_err = 1'b1;
        check("to_wr", 32'(RegWr), 32'd0);
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_ready", 32'(in_ready), 32'd1);
        check("to_cnt", retire_cnt, exp_cnt);
      end else begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        completed(rd, wen, ref_load(f3, lo, rdata));
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_reg_wen = 1'b0; in_wb_sel = '0;
    in_alu_result = '0; in_pc = '0; in_load_funct3 = '0; in_load_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    exp_rw = '0; exp_busw = '0; exp_cnt = '0; exp_err = 1'b0;
    tick();
    do_reset();

    // Directed scenarios
    do_op(2'b00, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    idle_cycle();
    do_op(2'b00, 5'd1, 1'b1, 32'hAAAA_0001, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    do_op(2'b00, 5'd2, 1'b1, 32'hAAAA_0002, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    do_op(2'b00, 5'd3, 1'b1, 32'hAAAA_0003, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    idle_cycle();
    do_op(2'b01, 5'd7, 1'b1, 32'h0, 32'h0, 3'b000, 2'd3, 32'h80FF_0000, 3);
    do_op(2'b01, 5'd8, 1'b1, 32'h0, 32'h0, 3'b101, 2'd2, 32'h80FF_0000, 2);
    do_op(2'b00, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    do_op(2'b10, 5'd1, 1'b1, 32'h0, 32'hFFFF_FFFC, 3'd0, 2'd0, 32'h0, 0);
    do_op(2'b01, 5'd9, 1'b1, 32'h0, 32'h0, 3'b010, 2'd0, 32'hCAFE_F00D, 20);
    idle_cycle();
    do_op(2'b01, 5'd10, 1'b1, 32'h0, 32'h0, 3'b001, 2'd1, 32'h1234_8765, 15);
    do_op(2'b01, 5'd11, 1'b0, 32'h0, 32'h0, 3'b010, 2'd0, 32'h5555_AAAA, 1);

    // Reset while a load waits, with the response arriving right after reset
    in_valid = 1'b1; in_wb_sel = 2'b01; in_rd = 5'd12; in_reg_wen = 1'b1;
    mem_rvalid = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    check("rstw_wr", 32'(RegWr), 32'd0);
    check("rstw_ready", 32'(in_ready), 32'd1);
    check_state("rstw");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int w;
      logic [1:0] sel;
      sel = 2'($urandom);
      w = ($urandom % 8 == 0) ? int'($urandom_range(MEM_TIMEOUT - 1, MEM_TIMEOUT + 1))
                              : int'($urandom_range(0, 5));
      do_op(sel, 5'($urandom), 1'($urandom), $urandom, $urandom,
            3'($urandom), 2'($urandom), $urandom, w);
      if ($urandom % 4 == 0) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Retirement stage that drives the register-file write port (Rw, RegWr, busW) consumed by the decode stage's register file.
- Accepts one retiring instruction per cycle from the execute/memory stage over a valid/ready handshake.
- Selects the ALU result, PC+4, or the load data, and sign- or zero-extends the load data. Loads stall until the memory response arrives.
- Writes to x0 are suppressed. Completed instructions are counted.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in WAIT_MEM before the load is abandoned.
- CNT_W, 32: width of the retire counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a retiring instruction is presented.
- in_ready  output  1  the unit can accept; a transfer occurs when in_valid && in_ready.
- in_rd  input  5  destination register index.
- in_reg_wen  input  1  the instruction writes rd.
- in_wb_sel  input  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 treated as ALU.
- in_alu_result  input  32  ALU result.
- in_pc  input  32  instruction PC.
- in_load_funct3  input  3  load type.
- in_load_addr_lo  input  2  low two bits of the load address.
- mem_rvalid  input  1  load data is valid this cycle.
- mem_rdata  input  32  raw aligned memory word.
- Rw  output  5  write register index to the register file.
- RegWr  output  1  write enable to the register file; a one-cycle pulse per write.
- busW  output  32  write data to the register file.
- retire_cnt  output  CNT_W  completed-instruction count.
- err_timeout  output  1  sticky flag: a load was abandoned by timeout.

Behaviour:
- Reset (clk edge with rst=1):
  - State returns to IDLE; any pending load is dropped.
  - Rw=0, RegWr=0, busW=0, retire_cnt=0, err_timeout=0, timeout counter=0.
  - Applies mid-WAIT_MEM as well; no write is issued for the dropped load.
- State IDLE:
  - in_ready=1.
  - On a transfer, all in_* fields are captured.
  - If in_wb_sel!=LOAD, or in_wb_sel==LOAD with mem_rvalid=1 in the same cycle, the instruction completes: outputs update on the next edge, so latency is 1 cycle and back-to-back transfers sustain 1 per cycle.
  - Otherwise the load moves to WAIT_MEM with the timeout counter cleared.
- State WAIT_MEM:
  - in_ready=0.
  - On mem_rvalid=1 the load completes at that edge (RegWr visible next cycle) and state returns to IDLE.
  - Otherwise the timeout counter increments.
  - When the counter reaches MEM_TIMEOUT-1 without a response: return to IDLE, set err_timeout, RegWr stays 0, and retire_cnt still increments.
- Completion:
  - Rw <= rd and busW <= result.
  - RegWr <= in_reg_wen && (rd!=0), pulsed for exactly one cycle; otherwise RegWr <= 0.
  - retire_cnt increments on every completion, including rd=0 and reg_wen=0; it wraps modulo 2^CNT_W.
  - Loads with reg_wen=0 still wait for and consume mem_rvalid.
- Rw and busW hold their last values when no completion occurs.
- Result selection:
  - ALU: in_alu_result.
  - PC+4: in_pc+32'd4, with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
- Load extension, with byte lane = addr_lo and half lane = addr_lo[1]:
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the selected half; addr_lo[0] is ignored, misaligned accesses are not trapped.
  - 101 LHU: zero-extend the selected half.
  - 010 LW, and 011/110/111: the full word; addr_lo is ignored.
- mem_rvalid is ignored in IDLE unless a load is accepted in that same cycle.

Test Plan:
- Reset, then ALU op rd=5, result 0x12345678 -> next cycle Rw=5, RegWr=1, busW=0x12345678, retire_cnt=1; the following cycle RegWr=0.
- Three back-to-back ALU ops rd=1,2,3 with in_valid held high -> in_ready stays 1; RegWr high for 3 consecutive cycles with Rw=1,2,3; retire_cnt=3.
- LB with addr_lo=3, rd=7, mem_rdata=0x80FF_0000 returned after 4 cycles -> in_ready=0 for those cycles; busW=0xFFFFFF80. LHU with addr_lo=2, same data -> busW=0x000080FF.
- ALU op with rd=0 -> RegWr stays 0, retire_cnt increments. PC+4 with pc=0xFFFFFFFC, rd=1 -> busW=0x00000000.
- Load with no mem_rvalid for MEM_TIMEOUT cycles -> err_timeout=1, no RegWr pulse, in_ready=1 again. rst asserted mid-WAIT_MEM with mem_rvalid on the next cycle -> no write, retire_cnt=0.
